// File: rtl/rf_cmd_sequencer.sv
// Queues host commands and issues them one at a time to the 8-entry register file; 3 cycles accept-to-response.
// cmd_ready drops while the FIFO is full; the response is held stable until the host asserts rsp_ready.
module rf_cmd_sequencer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [ADDR_W-1:0]           cmd_addr,
    input  logic [DATA_W-1:0]           cmd_data,
    output logic                        rf_wr,
    output logic                        rf_rd,
    output logic [ADDR_W-1:0]           rf_addr,
    output logic [DATA_W-1:0]           rf_din,
    input  logic [DATA_W-1:0]           rf_dout,
    input  logic                        rf_error,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [1:0]                  rsp_op,
    output logic [ADDR_W-1:0]           rsp_addr,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_error,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [7:0]                  err_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    cmd_t             mem [FIFO_DEPTH];
    cmd_t             push_ent;
    cmd_t             issue;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    state_t           state;
    state_t           state_nxt;

    // Nops are handshaken but never queued; read commands carry no write data.
    assign cmd_ready  = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready && (cmd_op != 2'b00);
    assign fifo_empty = (fifo_count == '0);
    assign push_ent   = '{op: cmd_op, addr: cmd_addr, data: (cmd_op[0] ? cmd_data : '0)};

    assign rf_addr = issue.addr;
    assign rf_din  = issue.data;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        rf_wr     = 1'b0;
        rf_rd     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                rf_wr     = issue.op[0];
                rf_rd     = issue.op[1];
                state_nxt = CAPT;
            end
            CAPT: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            issue      <= '0;
            rsp_valid  <= 1'b0;
            rsp_op     <= '0;
            rsp_addr   <= '0;
            rsp_data   <= '0;
            rsp_error  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                issue  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
            // rf_dout/rf_error are the file's registered answer to last cycle's strobe.
            if (state == CAPT) begin
                rsp_valid <= 1'b1;
                rsp_op    <= issue.op;
                rsp_addr  <= issue.addr;
                rsp_data  <= issue.op[1] ? rf_dout : '0;
                rsp_error <= rf_error;
                if (rf_error && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
            if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_cmd_sequencer.sv
// Bench for rf_cmd_sequencer: register-file device model, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rf_cmd_sequencer;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op    = '0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_data  = '0;
    logic          rf_wr;
    logic          rf_rd;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_din;
    logic [DW-1:0] rf_dout;
    logic          rf_error;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_op;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          rsp_error;
    logic [2:0]    fifo_count;
    logic [7:0]    err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // 0: hold rsp_ready low, 1: hold high, 2: random
    int   rdy_mode = 0;
    logic rnd_bit  = 1'b0;
    assign rsp_ready = (rdy_mode == 1) || ((rdy_mode == 2) && rnd_bit);

    always #5 clk = ~clk;

    rf_cmd_sequencer #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_addr(rf_addr), .rf_din(rf_din),
        .rf_dout(rf_dout), .rf_error(rf_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .fifo_count(fifo_count), .err_cnt(err_cnt)
    );

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register file device: registered response to the strobes.
    logic [DW-1:0] dev_mem [8];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) dev_mem[i] <= '0;
            rf_dout  <= '0;
            rf_error <= 1'b0;
        end else if (rf_wr && rf_rd) begin
            rf_dout  <= '0;
            rf_error <= 1'b1;
        end else if (rf_wr) begin
            dev_mem[rf_addr] <= rf_din;
            rf_dout  <= '0;
            rf_error <= 1'b0;
        end else if (rf_rd) begin
            rf_dout  <= dev_mem[rf_addr];
            rf_error <= 1'b0;
        end else begin
            rf_dout  <= '0;
            rf_error <= 1'b0;
        end
    end

    // Reference model: commands execute in accept order, so each expected response is
    // computed against a shadow memory at accept time. m_age = cycles since issue (-1 none).
    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] edata;
        logic          eerr;
    } txn_t;

    txn_t          pend_q[$];
    txn_t          cur;
    txn_t          t;
    logic [DW-1:0] ref_mem [8];
    int            m_cnt = 0;
    int            m_age = -1;
    int            m_err = 0;
    logic          s_reset = 1'b1;
    logic          s_valid = 1'b0;
    logic [1:0]    s_op = '0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_rdy = 1'b0;
    bit            hs, pop, push;

    always @(negedge clk) begin
        if (s_reset) begin
            pend_q.delete();
            m_cnt = 0;
            m_age = -1;
            m_err = 0;
            for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        end else begin
            hs   = (m_age >= 2) && s_rdy;
            pop  = (m_cnt > 0) && ((m_age < 0) || hs);
            push = s_valid && (m_cnt < DEPTH) && (s_op != 2'b00);
            if (m_age == 1) begin
                m_age = 2;
                if (cur.eerr && m_err < 255) m_err++;
            end else if (m_age == 0) begin
                m_age = 1;
            end
            if (hs) m_age = -1;
            if (pop) begin
                cur   = pend_q.pop_front();
                m_age = 0;
            end
            if (push) begin
                t.op   = s_op;
                t.addr = s_addr;
                t.din  = s_op[0] ? s_data : '0;
                t.eerr = (s_op == 2'b11);
                t.edata = (s_op == 2'b10) ? ref_mem[s_addr] : '0;
                if (s_op == 2'b01) ref_mem[s_addr] = s_data;
                pend_q.push_back(t);
            end
            m_cnt = m_cnt + int'(push) - int'(pop);
        end

        chk("fifo_count", 32'(fifo_count), m_cnt);
        chk("cmd_ready", 32'(cmd_ready), 32'(m_cnt < DEPTH));
        chk("rf_wr", 32'(rf_wr), (m_age == 0) ? 32'(cur.op[0]) : 0);
        chk("rf_rd", 32'(rf_rd), (m_age == 0) ? 32'(cur.op[1]) : 0);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_age >= 2));
        chk("err_cnt", 32'(err_cnt), m_err);
        if (m_age == 0) begin
            chk("rf_addr", 32'(rf_addr), 32'(cur.addr));
            if (cur.op[0]) chk("rf_din", 32'(rf_din), 32'(cur.din));
        end
        if (m_age >= 2) begin
            chk("rsp_op", 32'(rsp_op), 32'(cur.op));
            chk("rsp_addr", 32'(rsp_addr), 32'(cur.addr));
            chk("rsp_data", 32'(rsp_data), 32'(cur.edata));
            chk("rsp_error", 32'(rsp_error), 32'(cur.eerr));
        end

        s_reset = reset;
        s_valid = cmd_valid;
        s_op    = cmd_op;
        s_addr  = cmd_addr;
        s_data  = cmd_data;
        s_rdy   = rsp_ready;
    end

    // All host tasks are entered and left 1 time unit after a rising edge.
    task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit rdy = 0;
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        do begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 300);
        chk("send_accept", 32'(rdy), 1);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [1:0] op, output logic [AW-1:0] a,
                           output logic [DW-1:0] d, output logic e);
        bit got = 0;
        int n = 0;
        op = '0; a = '0; d = '0; e = 1'b0;
        rdy_mode = 1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                op = rsp_op; a = rsp_addr; d = rsp_data; e = rsp_error;
            end
            @(posedge clk);
            #1;
            n++;
        end
        rdy_mode = 0;
        chk("rsp_arrival", 32'(got), 1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
    endtask

    logic [1:0]    r_op;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_err;
    int            lat;
    int            nhs;
    bit            take;
    logic [AW-1:0] got_q[$];

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_rf_strobes", 32'({rf_wr, rf_rd}), 0);
        chk("rst_rf_addr", 32'(rf_addr), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_cycles(2);

        // Write then read back, with accept-to-response latency
        send(2'b01, 3'd3, 8'hA5);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (rsp_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        #1;
        chk("t1_latency", lat, 3);
        get_rsp(r_op, r_addr, r_data, r_err);
        chk("t1_wr_rsp", {22'd0, r_op, r_addr, r_data, r_err}, {22'd0, 2'b01, 3'd3, 8'h00, 1'b0});
        send(2'b10, 3'd3, 8'h00);
        get_rsp(r_op, r_addr, r_data, r_err);
        chk("t1_rd_rsp", {22'd0, r_op, r_addr, r_data, r_err}, {22'd0, 2'b10, 3'd3, 8'hA5, 1'b0});

        // Unwritten entry after reset
        do_reset();
        send(2'b10, 3'd5, 8'hFF);
        get_rsp(r_op, r_addr, r_data, r_err);
        chk("t2_rd_rsp", {23'd0, r_data, r_err}, {23'd0, 8'h00, 1'b0});
        chk("t2_err_cnt", 32'(err_cnt), 0);

        // Illegal read+write, then read of the same entry
        send(2'b11, 3'd2, 8'h3C);
        get_rsp(r_op, r_addr, r_data, r_err);
        chk("t3_ill_rsp", {23'd0, r_op, r_data, r_err}, {23'd0, 2'b11, 8'h00, 1'b1});
        chk("t3_err_cnt", 32'(err_cnt), 1);
        send(2'b10, 3'd2, 8'h00);
        get_rsp(r_op, r_addr, r_data, r_err);
        chk("t3_rd_after", {23'd0, r_data, r_err}, {23'd0, 8'h00, 1'b0});

        // Fill: 1 in flight + 4 queued, 6th blocked until a response is taken
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) send(2'b01, 3'(i), 8'(8'h10 + i));
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = 3'd5;
        cmd_data  = 8'h15;
        wait_cycles(3);
        @(negedge clk);
        chk("t4_full_count", 32'(fifo_count), 4);
        chk("t4_full_ready", 32'(cmd_ready), 0);
        chk("t4_held_valid", 32'(rsp_valid), 1);
        chk("t4_held_addr", 32'(rsp_addr), 0);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        got_q.delete();
        for (int i = 0; i < 80 && got_q.size() < 6; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) got_q.push_back(rsp_addr);
            take = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            if (take) cmd_valid = 1'b0;
        end
        rdy_mode = 0;
        chk("t4_rsp_count", got_q.size(), 6);
        for (int i = 0; i < got_q.size(); i++) chk("t4_rsp_order", 32'(got_q[i]), i);

        // Nop between two reads yields exactly two responses
        rdy_mode = 1;
        send(2'b10, 3'd1, 8'h00);
        send(2'b00, 3'd4, 8'h77);
        send(2'b10, 3'd2, 8'h00);
        nhs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) nhs++;
            @(posedge clk);
            #1;
        end
        chk("t5_rsp_count", nhs, 2);

        // Reset while the capture cycle is under way with two commands queued
        rdy_mode = 0;
        send(2'b10, 3'd1, 8'h00);
        send(2'b01, 3'd6, 8'h66);
        send(2'b11, 3'd7, 8'h77);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_pre_count", 32'(fifo_count), 2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rsp_valid", 32'(rsp_valid), 0);
        chk("t6_fifo_count", 32'(fifo_count), 0);
        chk("t6_cmd_ready", 32'(cmd_ready), 1);
        chk("t6_err_cnt", 32'(err_cnt), 0);
        chk("t6_strobes", 32'({rf_wr, rf_rd}), 0);
        @(posedge clk);
        #1;

        // Randomized traffic
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            wait_cycles($urandom_range(0, 2));
            send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom));
        end
        rdy_mode = 1;
        wait_cycles(30);

        // err_cnt saturation
        for (int i = 0; i < 260; i++) send(2'b11, 3'($urandom_range(0, 7)), 8'($urandom));
        wait_cycles(30);
        @(negedge clk);
        chk("sat_err_cnt", 32'(err_cnt), 255);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
